q_clk_source: RTL

//   Clocked token injector at the head of a q_stage pipeline. Drives the head

---
 rtl/q_clk_source_if.sv | 24 ++
 rtl/q_clk_source.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/q_clk_source_if.sv
// Bus between q_clk_source and the head of a q_stage pipeline.
// The master side is the token source. The slave side is the driver/consumer
// of the burst controls and the head-stage acknowledge.
interface q_clk_source_if #(
  parameter int unsigned CW = 8
) ();
  logic          start;
  logic [CW-1:0] count;
  logic          si;
  logic          so;
  logic          busy;
  logic          done;
  logic [CW-1:0] tokens_sent;

  modport master (
    input  start, count, si,
    output so, busy, done, tokens_sent
  );

  modport slave (
    output start, count, si,
    input  so, busy, done, tokens_sent
  );
endinterface

// File: rtl/q_clk_source.sv
// q_clk_source: clocked 4-phase token injector at the head of a q_stage pipeline.
// It issues `count` return-to-zero handshakes on so/si. It then pulses done.
// Optional feature macro: QSRC_TIMEOUT_EN adds a sticky ack-wait timeout output.
module q_clk_source #(
  parameter int unsigned CW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP         = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           rst,
  q_clk_source_if.master bus
`ifdef QSRC_TIMEOUT_EN
  ,
  output logic           timeout
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_GAP, S_DONE} state_t;

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          tokens_q, tokens_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   so_q, so_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ack;

  // Shift the asynchronous acknowledge through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.si};
  end

  assign ack = sync_q[SYNC_STAGES-1];

  // Next-state and burst bookkeeping. Outputs are registered from the next state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tokens_d = tokens_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tokens_d = '0;
          if (bus.count != '0) begin
            count_d = bus.count;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (ack) begin
          tokens_d = tokens_q + CW'(1);
          state_d  = S_REL;
        end
      end
      S_REL: begin
        if (!ack) begin
          if (tokens_q == count_q) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_REQ;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    so_d   = (state_d == S_REQ);
    busy_d = (state_d == S_REQ) || (state_d == S_REL) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      count_q  <= '0;
      tokens_q <= '0;
      gap_q    <= '0;
      so_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      count_q  <= count_d;
      tokens_q <= tokens_d;
      gap_q    <= gap_d;
      so_q     <= so_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.so          = so_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.tokens_sent = tokens_q;

`ifdef QSRC_TIMEOUT_EN
  logic [31:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic        entering;
  logic        waiting;

  // The wait counter restarts on each entry to REQ/REL and counts while the state holds.
  // The FSM itself keeps waiting after a timeout; the flag is only a report.
  always_comb begin
    wait_d    = wait_q;
    timeout_d = timeout_q;
    entering  = (state_d != state_q) && ((state_d == S_REQ) || (state_d == S_REL));
    waiting   = (state_d == state_q) && ((state_q == S_REQ) || (state_q == S_REL));
    if (entering) begin
      wait_d = '0;
    end else if (waiting && (wait_q != 32'(TIMEOUT))) begin
      wait_d = wait_q + 32'd1;
      if (wait_d == 32'(TIMEOUT)) timeout_d = 1'b1;
    end
  end

  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

endmodule
